// File: rtl/mmio_bridge.sv
// Memory-side stage behind the CPU data port: word-addressed data RAM plus a
// register page holding a TX FIFO, a status register and a free-running cycle counter.
module mmio_bridge #(
  parameter int n          = 16,
  parameter int ram_words  = 256,
  parameter int fifo_depth = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic [n-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready
);

  localparam int aw = $clog2(ram_words);
  localparam int pw = $clog2(fifo_depth);
  localparam logic [pw:0] full_count = (pw + 1)'(fifo_depth);

  localparam logic [7:0] off_txdata = 8'h00;
  localparam logic [7:0] off_status = 8'h02;
  localparam logic [7:0] off_cycle  = 8'h04;

  logic [n-1:0]  ram      [ram_words];
  logic [n-1:0]  fifo_mem [fifo_depth];
  logic [pw-1:0] rd_ptr;
  logic [pw-1:0] wr_ptr;
  logic [pw:0]   count;
  logic          overflow;
  logic [15:0]   cycle_count;

  logic          page_sel;
  logic [7:0]    offset;
  logic [aw-1:0] ram_idx;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;
  logic          cycle_load;
  logic          ram_we;
  logic [n-1:0]  status;

  // Address decode: the top byte all-ones selects the register page.
  assign page_sel = (addr[n-1:8] == '1);
  assign offset   = addr[7:0];
  assign ram_idx  = addr[aw:1];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == full_count);
  assign pop        = tx_valid & tx_ready;
  assign push_req   = memwrite & page_sel & (offset == off_txdata);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;
  assign ovf_clr    = memwrite & page_sel & (offset == off_status) & writedata[2];
  assign cycle_load = memwrite & page_sel & (offset == off_cycle);
  assign ram_we     = memwrite & ~page_sel;

  assign tx_valid = ~fifo_empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    status          = '0;
    status[0]       = fifo_empty;
    status[1]       = fifo_full;
    status[2]       = overflow;
    status[pw+4:4]  = count;
  end

  always_comb begin
    readdata = '0;
    if (page_sel) begin
      case (offset)
        off_status: readdata = status;
        off_cycle:  readdata = n'(cycle_count);
        default:    readdata = '0;
      endcase
    end else begin
      readdata = ram[ram_idx];
    end
  end

  // RAM and FIFO storage carry no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_idx] <= writedata;
    if (push)
      fifo_mem[wr_ptr] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (ovf_set)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle_count <= '0;
    else if (cycle_load)
      cycle_count <= writedata[15:0];
    else
      cycle_count <= cycle_count + 16'd1;
  end

endmodule
